// File: rtl/rle_bitmask_decoder_pkg.sv
// Shared widths and token classification for the zero-run bitmask decoder.
package rle_bitmask_decoder_pkg;

    localparam int W_DEF     = 32;
    localparam int RUN_W_DEF = 8;
    localparam int LOG2W     = $clog2(W_DEF);
    localparam int FREE_W    = LOG2W + 1;
    localparam int CONS_W    = RUN_W_DEF;

    typedef enum logic [1:0] {
        TOK_IDLE  = 2'd0,
        TOK_PLACE = 2'd1,
        TOK_SPILL = 2'd2
    } tok_case_e;

endpackage

// File: rtl/rle_bitmask_decoder_bit_decode.sv
// Index-to-one-hot decoder: sets bit i_idx of a W-bit mask.
module rle_bitmask_decoder_bit_decode #(
    parameter int W     = 32,
    parameter int LOG2W = $clog2(W)
) (
    input  logic [LOG2W-1:0] i_idx,
    output logic [W-1:0]     o_mask
);

    assign o_mask = {{(W-1){1'b0}}, 1'b1} << i_idx;

endmodule

// File: rtl/rle_bitmask_decoder.sv
// Expands zero-run tokens into MSB-first W-bit occupancy masks with a
// registered output stage and input back-pressure.
module rle_bitmask_decoder
    import rle_bitmask_decoder_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [RUN_W-1:0] i_in_run,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W-1:0]     o_out_data,
    output logic             o_out_last
);

    localparam int LW = $clog2(W);
    localparam int FW = LW + 1;
    localparam int CW = ((RUN_W > FW) ? RUN_W : FW) + 1;

    logic [W-1:0]     r_word;
    logic [FW-1:0]    r_free;
    logic [RUN_W-1:0] r_cons;

    logic [RUN_W-1:0] w_rem;
    logic [CW-1:0]    w_rem_x;
    logic [CW-1:0]    w_free_x;
    logic [CW-1:0]    w_pos_x;
    logic             w_place;
    logic [LW-1:0]    w_idx;
    logic [FW-1:0]    w_free_after;
    logic             w_need_slot;
    logic             w_slot;
    logic [W-1:0]     w_mask;
    logic [W-1:0]     w_word_set;
    tok_case_e        w_tok;

    logic             w_accept;
    logic             w_load;
    logic [W-1:0]     w_load_data;
    logic             w_load_last;
    logic [W-1:0]     w_word_nx;
    logic [FW-1:0]    w_free_nx;
    logic [RUN_W-1:0] w_cons_nx;

    // Zeros of the current token still to place; r_cons never exceeds i_in_run.
    assign w_rem        = i_in_run - r_cons;
    assign w_rem_x      = CW'(w_rem);
    assign w_free_x     = CW'(r_free);
    assign w_place      = (w_rem_x < w_free_x);
    assign w_pos_x      = w_free_x - w_rem_x - CW'(1);
    assign w_idx        = LW'(w_pos_x);
    assign w_free_after = FW'(w_pos_x);
    assign w_need_slot  = (w_free_after == '0) | i_in_last;
    assign w_slot       = ~o_out_valid | i_out_ready;
    assign w_word_set   = r_word | w_mask;

    rle_bitmask_decoder_bit_decode #(
        .W     (W),
        .LOG2W (LW)
    ) u_bit_decode (
        .i_idx  (w_idx),
        .o_mask (w_mask)
    );

    always_comb begin
        w_tok = TOK_IDLE;
        if (i_in_valid) begin
            w_tok = w_place ? TOK_PLACE : TOK_SPILL;
        end
    end

    always_comb begin
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_data = r_word;
        w_load_last = 1'b0;
        w_word_nx   = r_word;
        w_free_nx   = r_free;
        w_cons_nx   = r_cons;
        unique case (w_tok)
            TOK_PLACE: begin
                if (!w_need_slot) begin
                    w_accept  = 1'b1;
                    w_word_nx = w_word_set;
                    w_free_nx = w_free_after;
                    w_cons_nx = '0;
                end else if (w_slot) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = w_word_set;
                    w_load_last = i_in_last;
                    w_word_nx   = '0;
                    w_free_nx   = FW'(W);
                    w_cons_nx   = '0;
                end
            end
            TOK_SPILL: begin
                // Token stays on the input; its leading zeros finish this word.
                if (w_slot) begin
                    w_load      = 1'b1;
                    w_load_data = r_word;
                    w_load_last = 1'b0;
                    w_word_nx   = '0;
                    w_free_nx   = FW'(W);
                    w_cons_nx   = r_cons + RUN_W'(r_free);
                end
            end
            default: ;
        endcase
    end

    assign o_in_ready = w_accept;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word      <= '0;
            r_free      <= FW'(W);
            r_cons      <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_last  <= 1'b0;
        end else begin
            r_word <= w_word_nx;
            r_free <= w_free_nx;
            r_cons <= w_cons_nx;
            if (w_load) begin
                o_out_valid <= 1'b1;
                o_out_data  <= w_load_data;
                o_out_last  <= w_load_last;
            end else if (i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

    a_in_stable : assert property (@(posedge i_clk) disable iff (i_reset)
        (i_in_valid && !o_in_ready) |=>
        (i_in_valid && $stable(i_in_run) && $stable(i_in_last)));

endmodule

// File: tb/tb_rle_bitmask_decoder.sv
// Directed bench for rle_bitmask_decoder with hand-computed mask words.
module tb_rle_bitmask_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_in_run;
    logic        i_in_last;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_data;
    logic        o_out_last;

    int n_chk  = 0;
    int n_fail = 0;
    logic [32:0] q_out[$];

    rle_bitmask_decoder #(.W(32), .RUN_W(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_run    (i_in_run),
        .i_in_last   (i_in_last),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (!i_reset && o_out_valid && i_out_ready)
            q_out.push_back({o_out_last, o_out_data});
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one token (entered at posedge+1) until accepted; returns at posedge+1.
    task automatic send(input logic [7:0] run, input logic last, input int budget, output int cyc);
        logic rdy;
        logic done;
        i_in_valid = 1'b1;
        i_in_run   = run;
        i_in_last  = last;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge i_clk);
            rdy = o_in_ready;
            @(posedge i_clk);
            cyc++;
            if (rdy) done = 1'b1;
        end
        #1;
        i_in_valid = 1'b0;
        chk("accept", {32'd0, done}, 33'd1);
    endtask

    task automatic out_is(input string tag, input logic [31:0] data, input logic last);
        chk({tag, "_valid"}, {32'd0, o_out_valid}, 33'd1);
        chk({tag, "_data"},  {1'b0, o_out_data},   {1'b0, data});
        chk({tag, "_last"},  {32'd0, o_out_last},  {32'd0, last});
    endtask

    initial begin
        int c;
        int total;
        i_reset     = 1'b1;
        i_in_valid  = 1'b0;
        i_in_run    = '0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        chk("rst_valid", {32'd0, o_out_valid}, 33'd0);
        chk("rst_data",  {1'b0, o_out_data},   33'd0);
        chk("rst_last",  {32'd0, o_out_last},  33'd0);
        chk("rst_free",  {27'd0, dut.r_free},  33'd32);
        chk("rst_cons",  {25'd0, dut.r_cons},  33'd0);
        chk("rst_ready", {32'd0, o_in_ready},  33'd0);

        // 1: 32 single-bit tokens fill one word
        q_out.delete();
        total = 0;
        for (int i = 0; i < 32; i++) begin
            send(8'd0, (i == 31), 4, c);
            total += c;
        end
        chk("t1_cycles", total, 33'd32);
        out_is("t1", 32'hFFFF_FFFF, 1'b1);
        @(posedge i_clk); #1;
        chk("t1_count", q_out.size(), 33'd1);
        chk("t1_word",  q_out[0], {1'b1, 32'hFFFF_FFFF});

        // 2: run=31 closes a word at bit 0
        q_out.delete();
        send(8'd31, 1'b0, 4, c);
        out_is("t2a", 32'h0000_0001, 1'b0);
        send(8'd0, 1'b1, 4, c);
        out_is("t2b", 32'h8000_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t2_count", q_out.size(), 33'd2);

        // 3: run spanning three words
        q_out.delete();
        send(8'd70, 1'b1, 8, c);
        chk("t3_cycles", c, 33'd3);
        out_is("t3", 32'h0200_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t3_count", q_out.size(), 33'd3);
        chk("t3_w0", q_out[0], 33'd0);
        chk("t3_w1", q_out[1], 33'd0);
        chk("t3_w2", q_out[2], {1'b1, 32'h0200_0000});

        // 4: back-pressure while a word completes
        q_out.delete();
        i_out_ready = 1'b0;
        send(8'd0, 1'b1, 4, c);
        send(8'd1, 1'b0, 4, c);
        chk("t4_free_pre", {27'd0, dut.r_free}, 33'd30);
        i_in_valid = 1'b1;
        i_in_run   = 8'd0;
        i_in_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("t4_stall_rdy", {32'd0, o_in_ready}, 33'd0);
            chk("t4_hold_data", {1'b0, o_out_data}, {1'b0, 32'h8000_0000});
            chk("t4_hold_word", {1'b0, dut.r_word}, {1'b0, 32'h4000_0000});
            chk("t4_hold_free", {27'd0, dut.r_free}, 33'd30);
        end
        @(negedge i_clk);
        i_out_ready = 1'b1;
        #1;
        chk("t4_release_rdy", {32'd0, o_in_ready}, 33'd1);
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        out_is("t4b", 32'h6000_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t4_count", q_out.size(), 33'd2);
        chk("t4_w0", q_out[0], {1'b1, 32'h8000_0000});
        chk("t4_w1", q_out[1], {1'b1, 32'h6000_0000});

        // 5: reset in the middle of a long run
        i_in_valid = 1'b1;
        i_in_run   = 8'd70;
        i_in_last  = 1'b1;
        @(posedge i_clk); #1;
        chk("t5_first_valid", {32'd0, o_out_valid}, 33'd1);
        chk("t5_cons_mid", {25'd0, dut.r_cons}, 33'd32);
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        chk("t5_valid", {32'd0, o_out_valid}, 33'd0);
        chk("t5_free",  {27'd0, dut.r_free},  33'd32);
        chk("t5_cons",  {25'd0, dut.r_cons},  33'd0);
        q_out.delete();
        send(8'd3, 1'b1, 4, c);
        out_is("t5", 32'h1000_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t5_count", q_out.size(), 33'd1);

        // 6: a token after a flushed word starts fresh at bit 31
        q_out.delete();
        send(8'd3, 1'b1, 4, c);
        out_is("t6a", 32'h1000_0000, 1'b1);
        send(8'd0, 1'b1, 4, c);
        out_is("t6b", 32'h8000_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t6_count", q_out.size(), 33'd2);

        // 7: run exactly equal to the free bits ends the word in zeros
        q_out.delete();
        send(8'd1, 1'b0, 4, c);
        send(8'd30, 1'b1, 6, c);
        chk("t7_cycles", c, 33'd2);
        out_is("t7", 32'h8000_0000, 1'b1);
        @(posedge i_clk); #1;
        chk("t7_count", q_out.size(), 33'd2);
        chk("t7_w0", q_out[0], {1'b0, 32'h4000_0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
